execute_stage: RTL and testbench

//  RV pipeline EX stage between decode_stage (ID/EX outputs *E) and memory_stage (inputs *M).

---
 rtl/execute_stage_pkg.sv | 32 +++
 rtl/execute_stage_if.sv | 45 ++++
 rtl/execute_stage_mul.sv | 68 ++++++
 rtl/execute_stage.sv | 148 ++++++++++++++
 tb/tb_execute_stage.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU op select, memory access size,
// multiplier FSM states and default datapath widths.
package execute_stage_pkg;

   localparam int XLEN_DEF    = 64;
   localparam int SHAMT_W_DEF = 6;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_MUL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10,
      MEM_D = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'b00,
      MUL_BUSY = 2'b01,
      MUL_DONE = 2'b10
   } mul_state_e;

endpackage

// File: rtl/execute_stage_if.sv
// Bundle of ID/EX inputs, WB forwarding inputs and EX/MEM outputs around the
// execute stage. master = surrounding pipeline, slave = execute_stage.
interface execute_stage_if
   import execute_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
);
   // Flow control: while StallE is 1 the ID/EX inputs must be held unchanged;
   // an ID/EX instruction is consumed on the first rising edge with StallE 0,
   // or discarded on any edge with FlushE 1.
   logic             FlushE;
   logic             RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE, ALUSrcE;
   logic [2:0]       ALUOpE;
   logic [2:0]       Funct3E;
   logic [4:0]       Rs1E, Rs2E, RdE;
   logic [XLEN-1:0]  ImmE, PCPlus4E, ReadData1E, ReadData2E;

   logic             RegWriteEnW;
   logic [4:0]       RDW;
   logic [XLEN-1:0]  ResultW;

   logic             StallE;
   logic             RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM;
   mem_size_e        MemSizeM;
   logic [1:0]       LoadSizeM;
   logic [4:0]       RdM;
   logic [XLEN-1:0]  PcPlus4M, ReadData2M, ALUResultM;

   modport master (
      output FlushE, RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE, ALUSrcE,
             ALUOpE, Funct3E, Rs1E, Rs2E, RdE, ImmE, PCPlus4E, ReadData1E, ReadData2E,
             RegWriteEnW, RDW, ResultW,
      input  StallE, RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM,
             MemSizeM, LoadSizeM, RdM, PcPlus4M, ReadData2M, ALUResultM
   );

   modport slave (
      input  FlushE, RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE, ALUSrcE,
             ALUOpE, Funct3E, Rs1E, Rs2E, RdE, ImmE, PCPlus4E, ReadData1E, ReadData2E,
             RegWriteEnW, RDW, ResultW,
      output StallE, RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM,
             MemSizeM, LoadSizeM, RdM, PcPlus4M, ReadData2M, ALUResultM
   );

endinterface

// File: rtl/execute_stage_mul.sv
// Iterative shift-add multiplier: one multiplier bit per BUSY cycle, XLEN BUSY
// cycles, then one DONE cycle presenting the low XLEN bits of the product.
module iter_multiplier
   import execute_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] product_o,
   output mul_state_e      state_o
);

   localparam int              CNT_W    = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   mul_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  acc_q, mcand_q, mplier_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MUL_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         case (state_q)
            MUL_IDLE: begin
               if (start_i) begin
                  mcand_q  <= a_i;
                  mplier_q <= b_i;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= MUL_BUSY;
               end
            end
            MUL_BUSY: begin
               if (abort_i) begin
                  state_q <= MUL_IDLE;
               end else begin
                  // Bits shifted past XLEN are dropped: only the low half is kept.
                  if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  cnt_q    <= cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) state_q <= MUL_DONE;
               end
            end
            MUL_DONE: state_q <= MUL_IDLE;
            default:  state_q <= MUL_IDLE;
         endcase
      end
   end

   assign busy_o    = (state_q == MUL_BUSY);
   assign done_o    = (state_q == MUL_DONE);
   assign product_o = acc_q;
   assign state_o   = state_q;

endmodule

// File: rtl/execute_stage.sv
// RV execute stage: operand forwarding from MEM/WB, single-cycle ALU, iterative
// MUL with upstream stall, and the EX/MEM pipeline register.
module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   execute_stage_if.slave ex_if,
   output mul_state_e     mul_state_o
);

   logic            regwrite_m_q, memtoreg_m_q, jal_m_q, memread_m_q, memwrite_m_q;
   logic            regwrite_m_d, memtoreg_m_d, jal_m_d, memread_m_d, memwrite_m_d;
   mem_size_e       mem_size_m_q, mem_size_m_d;
   logic [1:0]      load_size_m_q, load_size_m_d;
   logic [4:0]      rd_m_q, rd_m_d;
   logic [XLEN-1:0] pc_plus4_m_q, pc_plus4_m_d;
   logic [XLEN-1:0] rd2_m_q, rd2_m_d;
   logic [XLEN-1:0] alu_m_q, alu_m_d;

   logic [XLEN-1:0] m_fwd_val, src_a, rs2_fwd, src_b, alu_result, mul_product;
   logic            mul_start, mul_busy, mul_done, stall_e, bubble;
   mul_state_e      mul_state;

   function automatic logic [XLEN-1:0] fwd(
      input logic [4:0]      rs,
      input logic [XLEN-1:0] rf_val,
      input logic            m_en,
      input logic [4:0]      m_rd,
      input logic [XLEN-1:0] m_val,
      input logic            w_en,
      input logic [4:0]      w_rd,
      input logic [XLEN-1:0] w_val
   );
      if (rs != 5'd0 && m_en && m_rd == rs) return m_val;
      if (rs != 5'd0 && w_en && w_rd == rs) return w_val;
      return rf_val;
   endfunction

   // A JAL in MEM writes its link address, not its ALU result.
   assign m_fwd_val = jal_m_q ? pc_plus4_m_q : alu_m_q;

   assign src_a   = fwd(ex_if.Rs1E, ex_if.ReadData1E, regwrite_m_q, rd_m_q, m_fwd_val,
                        ex_if.RegWriteEnW, ex_if.RDW, ex_if.ResultW);
   assign rs2_fwd = fwd(ex_if.Rs2E, ex_if.ReadData2E, regwrite_m_q, rd_m_q, m_fwd_val,
                        ex_if.RegWriteEnW, ex_if.RDW, ex_if.ResultW);
   assign src_b   = ex_if.ALUSrcE ? ex_if.ImmE : rs2_fwd;

   always_comb begin
      alu_result = '0;
      case (ex_if.ALUOpE)
         ALU_ADD: alu_result = src_a + src_b;
         ALU_SUB: alu_result = src_a - src_b;
         ALU_AND: alu_result = src_a & src_b;
         ALU_OR:  alu_result = src_a | src_b;
         ALU_XOR: alu_result = src_a ^ src_b;
         ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLL: alu_result = src_a << src_b[SHAMT_W-1:0];
         default: alu_result = '0;
      endcase
   end

   assign mul_start = (ex_if.ALUOpE == ALU_MUL) && !ex_if.FlushE;

   iter_multiplier #(.XLEN(XLEN)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (mul_start),
      .abort_i   (ex_if.FlushE),
      .a_i       (src_a),
      .b_i       (src_b),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_product),
      .state_o   (mul_state)
   );

   // Stall covers the entry cycle as well, so the MUL is not also committed as a single-cycle op.
   assign stall_e = !rst && (mul_busy || (mul_state == MUL_IDLE && mul_start));
   assign bubble  = ex_if.FlushE || stall_e;

   always_comb begin
      regwrite_m_d  = ex_if.RegWriteEnE & ~bubble;
      memtoreg_m_d  = ex_if.MemtoRegE   & ~bubble;
      jal_m_d       = ex_if.JALE        & ~bubble;
      memread_m_d   = ex_if.MemReadEnE  & ~bubble;
      memwrite_m_d  = ex_if.MemWriteEnE & ~bubble;
      rd_m_d        = bubble ? 5'd0 : ex_if.RdE;
      mem_size_m_d  = mem_size_m_q;
      load_size_m_d = load_size_m_q;
      pc_plus4_m_d  = pc_plus4_m_q;
      rd2_m_d       = rd2_m_q;
      alu_m_d       = alu_m_q;
      if (!bubble) begin
         mem_size_m_d  = mem_size_e'(ex_if.Funct3E[1:0]);
         load_size_m_d = {1'b0, ex_if.Funct3E[2]};
         pc_plus4_m_d  = ex_if.PCPlus4E;
         rd2_m_d       = rs2_fwd;
         alu_m_d       = mul_done ? mul_product : alu_result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regwrite_m_q  <= 1'b0;
         memtoreg_m_q  <= 1'b0;
         jal_m_q       <= 1'b0;
         memread_m_q   <= 1'b0;
         memwrite_m_q  <= 1'b0;
         mem_size_m_q  <= MEM_B;
         load_size_m_q <= 2'b00;
         rd_m_q        <= 5'd0;
         pc_plus4_m_q  <= '0;
         rd2_m_q       <= '0;
         alu_m_q       <= '0;
      end else begin
         regwrite_m_q  <= regwrite_m_d;
         memtoreg_m_q  <= memtoreg_m_d;
         jal_m_q       <= jal_m_d;
         memread_m_q   <= memread_m_d;
         memwrite_m_q  <= memwrite_m_d;
         mem_size_m_q  <= mem_size_m_d;
         load_size_m_q <= load_size_m_d;
         rd_m_q        <= rd_m_d;
         pc_plus4_m_q  <= pc_plus4_m_d;
         rd2_m_q       <= rd2_m_d;
         alu_m_q       <= alu_m_d;
      end
   end

   assign ex_if.StallE      = stall_e;
   assign ex_if.RegWriteEnM = regwrite_m_q;
   assign ex_if.MemtoRegM   = memtoreg_m_q;
   assign ex_if.JALM        = jal_m_q;
   assign ex_if.MemReadEnM  = memread_m_q;
   assign ex_if.MemWriteEnM = memwrite_m_q;
   assign ex_if.MemSizeM    = mem_size_m_q;
   assign ex_if.LoadSizeM   = load_size_m_q;
   assign ex_if.RdM         = rd_m_q;
   assign ex_if.PcPlus4M    = pc_plus4_m_q;
   assign ex_if.ReadData2M  = rd2_m_q;
   assign ex_if.ALUResultM  = alu_m_q;
   assign mul_state_o       = mul_state;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, ALU ops, forwarding priority,
// iterative MUL stall/result, flush and reset during MUL.
module tb_execute_stage;
   import execute_stage_pkg::*;

   logic       clk;
   logic       rst;
   mul_state_e mul_state;
   int         n_cmp;
   int         n_fail;

   execute_stage_if #(.XLEN(64)) ex_if ();

   execute_stage #(.XLEN(64), .SHAMT_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_if       (ex_if),
      .mul_state_o (mul_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ex_if.FlushE      = 1'b0;
      ex_if.RegWriteEnE = 1'b0;
      ex_if.MemtoRegE   = 1'b0;
      ex_if.JALE        = 1'b0;
      ex_if.MemReadEnE  = 1'b0;
      ex_if.MemWriteEnE = 1'b0;
      ex_if.ALUSrcE     = 1'b0;
      ex_if.ALUOpE      = 3'b000;
      ex_if.Funct3E     = 3'b000;
      ex_if.Rs1E        = 5'd0;
      ex_if.Rs2E        = 5'd0;
      ex_if.RdE         = 5'd0;
      ex_if.ImmE        = 64'd0;
      ex_if.PCPlus4E    = 64'd0;
      ex_if.ReadData1E  = 64'd0;
      ex_if.ReadData2E  = 64'd0;
      ex_if.RegWriteEnW = 1'b0;
      ex_if.RDW         = 5'd0;
      ex_if.ResultW     = 64'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      step();
      n_cmp++; if (ex_if.RegWriteEnM !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got %b exp 0", ex_if.RegWriteEnM); end
      n_cmp++; if (ex_if.ALUResultM !== 64'd0) begin n_fail++; $display("FAIL reset_alu got %h exp 0", ex_if.ALUResultM); end
      n_cmp++; if (ex_if.RdM !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d exp 0", ex_if.RdM); end
      n_cmp++; if (ex_if.StallE !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", ex_if.StallE); end
      n_cmp++; if (mul_state !== MUL_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", mul_state, MUL_IDLE); end
      rst = 1'b0;
   endtask

   task automatic test_add();
      clear_inputs();
      ex_if.RegWriteEnE = 1'b1;
      ex_if.ALUOpE      = ALU_ADD;
      ex_if.Funct3E     = 3'b011;
      ex_if.Rs1E        = 5'd1;
      ex_if.Rs2E        = 5'd2;
      ex_if.RdE         = 5'd5;
      ex_if.ReadData1E  = 64'd5;
      ex_if.ReadData2E  = 64'd7;
      step();
      n_cmp++; if (ex_if.ALUResultM !== 64'd12) begin n_fail++; $display("FAIL add_result got %h exp c", ex_if.ALUResultM); end
      n_cmp++; if (ex_if.RegWriteEnM !== 1'b1) begin n_fail++; $display("FAIL add_regwrite got %b exp 1", ex_if.RegWriteEnM); end
      n_cmp++; if (ex_if.RdM !== 5'd5) begin n_fail++; $display("FAIL add_rd got %0d exp 5", ex_if.RdM); end
      n_cmp++; if (ex_if.MemSizeM !== MEM_D) begin n_fail++; $display("FAIL add_memsize got %b exp 11", ex_if.MemSizeM); end
      n_cmp++; if (ex_if.ReadData2M !== 64'd7) begin n_fail++; $display("FAIL add_rd2 got %h exp 7", ex_if.ReadData2M); end
   endtask

   task automatic test_back_to_back();
      // I1: x3 = 0 + 9
      clear_inputs();
      ex_if.RegWriteEnE = 1'b1;
      ex_if.ALUSrcE     = 1'b1;
      ex_if.ImmE        = 64'd9;
      ex_if.RdE         = 5'd3;
      step();
      // I2: x3 + x0 with a stale RF value and an older x3 in WB
      clear_inputs();
      ex_if.RegWriteEnE = 1'b1;
      ex_if.Rs1E        = 5'd3;
      ex_if.ReadData1E  = 64'd100;
      ex_if.RdE         = 5'd6;
      ex_if.RegWriteEnW = 1'b1;
      ex_if.RDW         = 5'd3;
      ex_if.ResultW     = 64'd4;
      step();
      n_cmp++; if (ex_if.ALUResultM !== 64'd9) begin n_fail++; $display("FAIL fwd_m_priority got %h exp 9", ex_if.ALUResultM); end
      // JAL in M forwards its link address
      clear_inputs();
      ex_if.RegWriteEnE = 1'b1;
      ex_if.JALE        = 1'b1;
      ex_if.RdE         = 5'd1;
      ex_if.PCPlus4E    = 64'h104;
      ex_if.ALUSrcE     = 1'b1;
      ex_if.ImmE        = 64'h55;
      step();
      n_cmp++; if (ex_if.JALM !== 1'b1) begin n_fail++; $display("FAIL jal_ctrl got %b exp 1", ex_if.JALM); end
      clear_inputs();
      ex_if.RegWriteEnE = 1'b1;
      ex_if.Rs1E        = 5'd1;
      ex_if.ALUSrcE     = 1'b1;
      ex_if.RdE         = 5'd2;
      step();
      n_cmp++; if (ex_if.ALUResultM !== 64'h104) begin n_fail++; $display("FAIL fwd_jal got %h exp 104", ex_if.ALUResultM); end
   endtask

   task automatic test_w_forward();
      clear_inputs();
      step();
      // SW x4, 8(x2) with x4 only available from WB
      ex_if.MemWriteEnE = 1'b1;
      ex_if.ALUSrcE     = 1'b1;
      ex_if.ImmE        = 64'd8;
      ex_if.Funct3E     = 3'b010;
      ex_if.Rs1E        = 5'd2;
      ex_if.Rs2E        = 5'd4;
      ex_if.ReadData1E  = 64'h1000;
      ex_if.ReadData2E  = 64'h55;
      ex_if.RegWriteEnW = 1'b1;
      ex_if.RDW         = 5'd4;
      ex_if.ResultW     = 64'd20;
      step();
      n_cmp++; if (ex_if.ReadData2M !== 64'd20) begin n_fail++; $display("FAIL fwd_w_store got %h exp 14", ex_if.ReadData2M); end
      n_cmp++; if (ex_if.ALUResultM !== 64'h1008) begin n_fail++; $display("FAIL sw_addr got %h exp 1008", ex_if.ALUResultM); end
      n_cmp++; if (ex_if.MemWriteEnM !== 1'b1 || ex_if.RegWriteEnM !== 1'b0) begin n_fail++; $display("FAIL sw_ctrl got we=%b rw=%b exp we=1 rw=0", ex_if.MemWriteEnM, ex_if.RegWriteEnM); end
      n_cmp++; if (ex_if.MemSizeM !== MEM_W) begin n_fail++; $display("FAIL sw_size got %b exp 10", ex_if.MemSizeM); end
      // x0 as destination in M and W must never forward
      clear_inputs();
      ex_if.RegWriteEnE = 1'b1;
      ex_if.ALUSrcE     = 1'b1;
      ex_if.ImmE        = 64'd77;
      ex_if.RdE         = 5'd0;
      step();
      clear_inputs();
      ex_if.RegWriteEnE = 1'b1;
      ex_if.ALUSrcE     = 1'b1;
      ex_if.ImmE        = 64'd1;
      ex_if.RdE         = 5'd9;
      ex_if.Funct3E     = 3'b100;
      ex_if.RegWriteEnW = 1'b1;
      ex_if.RDW         = 5'd0;
      ex_if.ResultW     = 64'd99;
      step();
      n_cmp++; if (ex_if.ALUResultM !== 64'd1) begin n_fail++; $display("FAIL fwd_x0 got %h exp 1", ex_if.ALUResultM); end
      n_cmp++; if (ex_if.LoadSizeM !== 2'b01) begin n_fail++; $display("FAIL load_unsigned got %b exp 01", ex_if.LoadSizeM); end
   endtask

   task automatic test_alu_ops();
      logic [2:0]  ops [9];
      logic [63:0] va  [9];
      logic [63:0] vb  [9];
      logic [63:0] ve  [9];
      ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLT, ALU_SLL, ALU_SLL};
      va  = '{64'hF0, 64'h3C, 64'hF0, 64'hF0, 64'hF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 64'd3};
      vb  = '{64'h3C, 64'hF0, 64'h3C, 64'h3C, 64'h3C, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 64'h41};
      ve  = '{64'h12C, 64'hFFFF_FFFF_FFFF_FF4C, 64'h30, 64'hFC, 64'hCC, 64'd1, 64'd0,
              64'h8000_0000_0000_0000, 64'd6};
      for (int i = 0; i < 9; i++) begin
         clear_inputs();
         ex_if.RegWriteEnE = 1'b1;
         ex_if.RdE         = 5'd10;
         ex_if.ALUOpE      = ops[i];
         ex_if.ReadData1E  = va[i];
         ex_if.ReadData2E  = vb[i];
         step();
         n_cmp++; if (ex_if.ALUResultM !== ve[i]) begin n_fail++; $display("FAIL alu_op%0d_vec%0d got %h exp %h", ops[i], i, ex_if.ALUResultM, ve[i]); end
      end
   endtask

   task automatic test_mul();
      int   stall_cycles;
      logic bubble_bad;
      // I1: x5 = all ones, consumed by the MUL through M forwarding
      clear_inputs();
      ex_if.RegWriteEnE = 1'b1;
      ex_if.ALUSrcE     = 1'b1;
      ex_if.ImmE        = 64'hFFFF_FFFF_FFFF_FFFF;
      ex_if.RdE         = 5'd5;
      step();
      clear_inputs();
      ex_if.RegWriteEnE = 1'b1;
      ex_if.ALUOpE      = ALU_MUL;
      ex_if.Rs1E        = 5'd5;
      ex_if.Rs2E        = 5'd6;
      ex_if.ReadData2E  = 64'd3;
      ex_if.RdE         = 5'd7;
      #1;
      n_cmp++; if (ex_if.StallE !== 1'b1) begin n_fail++; $display("FAIL mul_stall_entry got %b exp 1", ex_if.StallE); end
      stall_cycles = 0;
      bubble_bad   = 1'b0;
      while (ex_if.StallE === 1'b1 && stall_cycles < 200) begin
         stall_cycles++;
         if (stall_cycles == 10) begin
            // A later WB write to the source regs must not disturb captured operands.
            ex_if.RegWriteEnW = 1'b1;
            ex_if.RDW         = 5'd5;
            ex_if.ResultW     = 64'd0;
         end
         step();
         if (ex_if.RegWriteEnM !== 1'b0 || ex_if.RdM !== 5'd0 || ex_if.MemWriteEnM !== 1'b0) bubble_bad = 1'b1;
      end
      // Entry cycle plus XLEN BUSY cycles
      n_cmp++; if (stall_cycles != 65) begin n_fail++; $display("FAIL mul_stall_len got %0d exp 65", stall_cycles); end
      n_cmp++; if (bubble_bad !== 1'b0) begin n_fail++; $display("FAIL mul_bubbles got %b exp 0", bubble_bad); end
      n_cmp++; if (mul_state !== MUL_DONE) begin n_fail++; $display("FAIL mul_done_state got %0d exp %0d", mul_state, MUL_DONE); end
      step();
      n_cmp++; if (ex_if.ALUResultM !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL mul_result got %h exp fffffffffffffffd", ex_if.ALUResultM); end
      n_cmp++; if (ex_if.RegWriteEnM !== 1'b1 || ex_if.RdM !== 5'd7) begin n_fail++; $display("FAIL mul_writeback got rw=%b rd=%0d exp rw=1 rd=7", ex_if.RegWriteEnM, ex_if.RdM); end
      n_cmp++; if (mul_state !== MUL_IDLE) begin n_fail++; $display("FAIL mul_back_idle got %0d exp %0d", mul_state, MUL_IDLE); end
      clear_inputs();
   endtask

   task automatic test_flush_mul();
      clear_inputs();
      step();
      ex_if.RegWriteEnE = 1'b1;
      ex_if.ALUOpE      = ALU_MUL;
      ex_if.Rs1E        = 5'd1;
      ex_if.Rs2E        = 5'd2;
      ex_if.ReadData1E  = 64'd6;
      ex_if.ReadData2E  = 64'd7;
      ex_if.RdE         = 5'd8;
      for (int i = 0; i < 10; i++) step();
      ex_if.FlushE = 1'b1;
      #1;
      n_cmp++; if (ex_if.StallE !== 1'b1) begin n_fail++; $display("FAIL flush_stall_before got %b exp 1", ex_if.StallE); end
      step();
      n_cmp++; if (ex_if.StallE !== 1'b0) begin n_fail++; $display("FAIL flush_stall_after got %b exp 0", ex_if.StallE); end
      n_cmp++; if (mul_state !== MUL_IDLE) begin n_fail++; $display("FAIL flush_state got %0d exp %0d", mul_state, MUL_IDLE); end
      n_cmp++; if (ex_if.RegWriteEnM !== 1'b0 || ex_if.RdM !== 5'd0) begin n_fail++; $display("FAIL flush_bubble got rw=%b rd=%0d exp rw=0 rd=0", ex_if.RegWriteEnM, ex_if.RdM); end
      clear_inputs();
      step();
      n_cmp++; if (ex_if.RegWriteEnM !== 1'b0 || ex_if.ALUResultM === 64'd42) begin n_fail++; $display("FAIL flush_no_write got rw=%b res=%h exp rw=0 res!=2a", ex_if.RegWriteEnM, ex_if.ALUResultM); end
   endtask

   task automatic test_reset_mid_mul();
      clear_inputs();
      ex_if.RegWriteEnE = 1'b1;
      ex_if.MemReadEnE  = 1'b1;
      ex_if.PCPlus4E    = 64'h40;
      ex_if.ReadData1E  = 64'd2;
      ex_if.ReadData2E  = 64'd3;
      ex_if.RdE         = 5'd4;
      ex_if.Funct3E     = 3'b111;
      step();
      ex_if.ALUOpE = ALU_MUL;
      ex_if.RdE    = 5'd11;
      for (int i = 0; i < 5; i++) step();
      rst          = 1'b1;
      ex_if.FlushE = 1'b1;
      step();
      n_cmp++; if (ex_if.StallE !== 1'b0) begin n_fail++; $display("FAIL rst_mul_stall got %b exp 0", ex_if.StallE); end
      n_cmp++; if (mul_state !== MUL_IDLE) begin n_fail++; $display("FAIL rst_mul_state got %0d exp %0d", mul_state, MUL_IDLE); end
      n_cmp++; if (ex_if.PcPlus4M !== 64'd0 || ex_if.ALUResultM !== 64'd0 || ex_if.ReadData2M !== 64'd0) begin n_fail++; $display("FAIL rst_mul_data got pc=%h alu=%h rd2=%h exp 0", ex_if.PcPlus4M, ex_if.ALUResultM, ex_if.ReadData2M); end
      n_cmp++; if (ex_if.MemReadEnM !== 1'b0 || ex_if.MemSizeM !== MEM_B || ex_if.LoadSizeM !== 2'b00) begin n_fail++; $display("FAIL rst_mul_ctrl got rd=%b sz=%b ls=%b exp 0", ex_if.MemReadEnM, ex_if.MemSizeM, ex_if.LoadSizeM); end
      rst = 1'b0;
      clear_inputs();
      step();
      n_cmp++; if (mul_state !== MUL_IDLE || ex_if.StallE !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got st=%0d stall=%b exp 0", mul_state, ex_if.StallE); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      clear_inputs();
      test_reset();
      test_add();
      test_back_to_back();
      test_w_forward();
      test_alu_ops();
      test_mul();
      test_flush_mul();
      test_reset_mid_mul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
